// File: rtl/bus_master_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | bus_master_arbiter_pkg: requester indices and arbiter state encoding |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package bus_master_arbiter_pkg;

  localparam int MASTER_DMMU   = 0;
  localparam int MASTER_IMMU   = 1;
  localparam int MASTER_DCACHE = 2;
  localparam int MASTER_ICACHE = 3;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Increment an index modulo n without relying on power-of-two widths.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_master_arbiter_rr_picker.sv
// +----------------------------------------------------------------------+
// | bus_master_arbiter_rr_picker: first request at or after ptr, wrapping |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module bus_master_arbiter_rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] index
);

  localparam int IW = $clog2(N);

  logic found;
  int   cand;

  always_comb begin
    gnt   = '0;
    index = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        index     = IW'(cand);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_master_arbiter.sv
// +----------------------------------------------------------------------+
// | bus_master_arbiter: round-robin Wishbone master arbiter with watchdog |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module bus_master_arbiter
  import bus_master_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_WIDTH       = 11
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_MASTERS-1:0]       m_cyc_i,
  input  logic [NUM_MASTERS-1:0]       m_stb_i,
  input  logic [NUM_MASTERS-1:0]       m_we_i,
  input  logic [NUM_MASTERS-1:0][31:0] m_adr_i,
  input  logic [NUM_MASTERS-1:0][31:0] m_dat_i,
  input  logic [NUM_MASTERS-1:0][3:0]  m_sel_i,
  output logic [31:0]                  m_dat_o,
  output logic [NUM_MASTERS-1:0]       m_ack_o,
  output logic [NUM_MASTERS-1:0]       m_err_o,
  output logic [NUM_MASTERS-1:0]       m_rty_o,
  output logic                         s_cyc_o,
  output logic                         s_stb_o,
  output logic                         s_we_o,
  output logic [31:0]                  s_adr_o,
  output logic [31:0]                  s_dat_o,
  output logic [3:0]                   s_sel_o,
  input  logic [31:0]                  s_dat_i,
  input  logic                         s_ack_i,
  input  logic                         s_err_i,
  input  logic                         s_rty_i,
  output logic [NUM_MASTERS-1:0]       grant_o,
  output logic                         timeout_o
);

  localparam int                IW      = $clog2(NUM_MASTERS);
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  arb_state_t           state, state_next;
  logic [NUM_MASTERS-1:0] grant, grant_next;
  logic [IW-1:0]        gidx, gidx_next;
  logic [IW-1:0]        rr_ptr, rr_ptr_next;
  logic [TO_WIDTH-1:0]  wd_cnt, wd_cnt_next;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IW-1:0]          pick_idx;
  logic                   resp;

  bus_master_arbiter_rr_picker #(
    .N (NUM_MASTERS)
  ) u_picker (
    .req   (m_cyc_i),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .index (pick_idx)
  );

  assign grant_o = grant;
  assign resp    = s_ack_i | s_err_i | s_rty_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ARB_IDLE;
      grant  <= '0;
      gidx   <= '0;
      rr_ptr <= '0;
      wd_cnt <= '0;
    end else begin
      state  <= state_next;
      grant  <= grant_next;
      gidx   <= gidx_next;
      rr_ptr <= rr_ptr_next;
      wd_cnt <= wd_cnt_next;
    end
  end

  always_comb begin
    state_next  = state;
    grant_next  = grant;
    gidx_next   = gidx;
    rr_ptr_next = rr_ptr;
    wd_cnt_next = '0;
    m_dat_o     = s_dat_i;
    m_ack_o     = '0;
    m_err_o     = '0;
    m_rty_o     = '0;
    s_cyc_o     = 1'b0;
    s_stb_o     = 1'b0;
    s_we_o      = 1'b0;
    s_adr_o     = '0;
    s_dat_o     = '0;
    s_sel_o     = '0;
    timeout_o   = 1'b0;

    case (state)
      ARB_IDLE: begin
        if (|m_cyc_i) begin
          state_next = ARB_BUSY;
          grant_next = pick_gnt;
          gidx_next  = pick_idx;
        end
      end

      ARB_BUSY: begin
        s_cyc_o = m_cyc_i[gidx];
        s_stb_o = m_stb_i[gidx];
        s_we_o  = m_we_i[gidx];
        s_adr_o = m_adr_i[gidx];
        s_dat_o = m_dat_i[gidx];
        s_sel_o = m_sel_i[gidx];
        m_ack_o[gidx] = s_ack_i;
        m_err_o[gidx] = s_err_i;
        m_rty_o[gidx] = s_rty_i;

        // A real slave response in the firing cycle suppresses the forced error.
        if (s_stb_o && !resp) begin
          if (wd_cnt == TO_LAST) begin
            timeout_o     = 1'b1;
            m_err_o[gidx] = 1'b1;
            wd_cnt_next   = '0;
          end else if (wd_cnt != '1) begin
            wd_cnt_next = wd_cnt + 1'b1;
          end else begin
            wd_cnt_next = wd_cnt;
          end
        end

        // Release leaves a dead cycle: the next owner is picked from IDLE.
        if (!m_cyc_i[gidx]) begin
          state_next  = ARB_IDLE;
          grant_next  = '0;
          rr_ptr_next = IW'(wrap_inc(int'(gidx), NUM_MASTERS));
          wd_cnt_next = '0;
        end
      end

      default: begin
        state_next = ARB_IDLE;
        grant_next = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_master_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_bus_master_arbiter: directed self-checking bench for the arbiter  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bus_master_arbiter;
  import bus_master_arbiter_pkg::*;

  logic             clk;
  logic             rst;
  logic [3:0]       m_cyc, m_stb, m_we;
  logic [3:0][31:0] m_adr, m_dat;
  logic [3:0][3:0]  m_sel;
  logic [31:0]      m_dat_o;
  logic [3:0]       m_ack_o, m_err_o, m_rty_o;
  logic             s_cyc_o, s_stb_o, s_we_o;
  logic [31:0]      s_adr_o, s_dat_o;
  logic [3:0]       s_sel_o;
  logic [31:0]      s_dat_i;
  logic             s_ack_i, s_err_i, s_rty_i;
  logic [3:0]       grant_o;
  logic             timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  bus_master_arbiter #(
    .NUM_MASTERS    (4),
    .TIMEOUT_CYCLES (16),
    .TO_WIDTH       (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_cyc_i   (m_cyc),
    .m_stb_i   (m_stb),
    .m_we_i    (m_we),
    .m_adr_i   (m_adr),
    .m_dat_i   (m_dat),
    .m_sel_i   (m_sel),
    .m_dat_o   (m_dat_o),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .m_rty_o   (m_rty_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_sel_o   (s_sel_o),
    .s_dat_i   (s_dat_i),
    .s_ack_i   (s_ack_i),
    .s_err_i   (s_err_i),
    .s_rty_i   (s_rty_i),
    .grant_o   (grant_o),
    .timeout_o (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_adr = '0; m_dat = '0; m_sel = '0;
    m_adr[0] = 32'hDEAD_BEEF;
    s_dat_i = 32'h1234_5678; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if ({s_cyc_o, s_stb_o, s_we_o, timeout_o} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {s_cyc_o, s_stb_o, s_we_o, timeout_o});
    end
    n_checks++;
    if ({grant_o, m_ack_o, m_err_o, m_rty_o} !== 16'h0) begin
      n_fail++; $display("FAIL reset_vec: got %h expected 0000", {grant_o, m_ack_o, m_err_o, m_rty_o});
    end
    n_checks++;
    if (s_adr_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_adr: got %h expected 00000000", s_adr_o);
    end
    n_checks++;
    if (m_dat_o !== 32'h1234_5678) begin
      n_fail++; $display("FAIL reset_dat_bcast: got %h expected 12345678", m_dat_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    m_cyc[MASTER_ICACHE] = 1'b1; m_stb[MASTER_ICACHE] = 1'b1;
    m_adr[MASTER_ICACHE] = 32'h8000_0000; m_sel[MASTER_ICACHE] = 4'hF;
    #1;
    n_checks++;
    if (s_cyc_o !== 1'b0) begin
      n_fail++; $display("FAIL single_req_cycle_cyc: got %b expected 0", s_cyc_o);
    end
    @(negedge clk); #1;
    n_checks++;
    if (grant_o !== 4'b1000) begin
      n_fail++; $display("FAIL single_grant: got %b expected 1000", grant_o);
    end
    n_checks++;
    if ({s_cyc_o, s_stb_o, s_adr_o, s_sel_o} !== {2'b11, 32'h8000_0000, 4'hF}) begin
      n_fail++; $display("FAIL single_bus: got %b %b %h %h expected 1 1 80000000 f", s_cyc_o, s_stb_o, s_adr_o, s_sel_o);
    end
    n_checks++;
    if (m_ack_o !== 4'b0) begin
      n_fail++; $display("FAIL single_early_ack1: got %b expected 0000", m_ack_o);
    end
    @(negedge clk); #1;
    n_checks++;
    if (m_ack_o !== 4'b0) begin
      n_fail++; $display("FAIL single_early_ack2: got %b expected 0000", m_ack_o);
    end
    @(negedge clk);
    s_ack_i = 1'b1; s_dat_i = 32'hCAFE_F00D;
    #1;
    n_checks++;
    if (m_ack_o !== 4'b1000) begin
      n_fail++; $display("FAIL single_ack: got %b expected 1000", m_ack_o);
    end
    n_checks++;
    if (m_dat_o !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL single_rdata: got %h expected cafef00d", m_dat_o);
    end
    @(negedge clk);
    s_ack_i = 1'b0; m_cyc[MASTER_ICACHE] = 1'b0; m_stb[MASTER_ICACHE] = 1'b0;
    #1;
    n_checks++;
    if ({s_cyc_o, m_ack_o} !== 5'b0) begin
      n_fail++; $display("FAIL single_release: got %b expected 00000", {s_cyc_o, m_ack_o});
    end
    @(negedge clk); #1;
    n_checks++;
    if (grant_o !== 4'b0) begin
      n_fail++; $display("FAIL single_idle_grant: got %b expected 0000", grant_o);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      m_dat[i] = 32'h1000_0000 + 32'(i);
      m_we[i]  = i[0];
    end
    m_cyc = 4'b1111; m_stb = 4'b1111;
    for (int e = 0; e < 4; e++) begin
      exp_g = 4'(1 << e);
      @(negedge clk);
      s_ack_i = (e != 1); s_rty_i = (e == 1);
      #1;
      n_checks++;
      if (grant_o !== exp_g) begin
        n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", e, grant_o, exp_g);
      end
      n_checks++;
      if ({s_we_o, s_dat_o} !== {e[0], 32'h1000_0000 + 32'(e)}) begin
        n_fail++; $display("FAIL rr_wdata%0d: got %b %h expected %b %h", e, s_we_o, s_dat_o, e[0], 32'h1000_0000 + 32'(e));
      end
      n_checks++;
      if ({m_ack_o, m_rty_o} !== ((e == 1) ? {4'b0, exp_g} : {exp_g, 4'b0})) begin
        n_fail++; $display("FAIL rr_resp%0d: got %b %b expected grantee bit only", e, m_ack_o, m_rty_o);
      end
      @(negedge clk);
      s_ack_i = 1'b0; s_rty_i = 1'b0; m_cyc[e] = 1'b0; m_stb[e] = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if ({grant_o, s_cyc_o} !== 5'b0) begin
        n_fail++; $display("FAIL rr_dead%0d: got %b expected 00000", e, {grant_o, s_cyc_o});
      end
    end
    m_we = '0; m_dat = '0;
  endtask

  task automatic test_refill_no_preempt();
    @(negedge clk);
    m_cyc[MASTER_ICACHE] = 1'b1; m_stb[MASTER_ICACHE] = 1'b1;
    m_adr[MASTER_ICACHE] = 32'h8000_0000;
    @(negedge clk);
    s_ack_i = 1'b1;
    #1;
    n_checks++;
    if ({grant_o, m_ack_o, s_adr_o} !== {4'b1000, 4'b1000, 32'h8000_0000}) begin
      n_fail++; $display("FAIL refill_beat0: got %b %b %h expected 1000 1000 80000000", grant_o, m_ack_o, s_adr_o);
    end
    for (int b = 1; b < 4; b++) begin
      @(negedge clk);
      s_ack_i = 1'b0; m_stb[MASTER_ICACHE] = 1'b0;
      if (b == 1) begin
        m_cyc[MASTER_DCACHE] = 1'b1; m_stb[MASTER_DCACHE] = 1'b1;
        m_adr[MASTER_DCACHE] = 32'h4000_0000;
      end
      #1;
      n_checks++;
      if ({grant_o, m_ack_o} !== {4'b1000, 4'b0000}) begin
        n_fail++; $display("FAIL refill_gap%0d: got %b %b expected 1000 0000", b, grant_o, m_ack_o);
      end
      @(negedge clk);
      m_stb[MASTER_ICACHE] = 1'b1;
      m_adr[MASTER_ICACHE] = 32'h8000_0000 + 32'(4 * b);
      s_ack_i = 1'b1;
      #1;
      n_checks++;
      if ({grant_o, m_ack_o, s_adr_o} !== {4'b1000, 4'b1000, 32'h8000_0000 + 32'(4 * b)}) begin
        n_fail++; $display("FAIL refill_beat%0d: got %b %b %h expected 1000 1000 %h", b, grant_o, m_ack_o, s_adr_o, 32'h8000_0000 + 32'(4 * b));
      end
    end
    @(negedge clk);
    s_ack_i = 1'b0; m_cyc[MASTER_ICACHE] = 1'b0; m_stb[MASTER_ICACHE] = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (grant_o !== 4'b0) begin
      n_fail++; $display("FAIL refill_dead: got %b expected 0000", grant_o);
    end
    @(negedge clk); #1;
    n_checks++;
    if ({grant_o, s_adr_o} !== {4'b0100, 32'h4000_0000}) begin
      n_fail++; $display("FAIL refill_dcache_grant: got %b %h expected 0100 40000000", grant_o, s_adr_o);
    end
    @(negedge clk);
    s_ack_i = 1'b1;
    @(negedge clk);
    s_ack_i = 1'b0; m_cyc[MASTER_DCACHE] = 1'b0; m_stb[MASTER_DCACHE] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    @(negedge clk);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk); #1;
      if (k == 1) begin
        n_checks++;
        if (grant_o !== 4'b0001) begin
          n_fail++; $display("FAIL to_grant0: got %b expected 0001", grant_o);
        end
      end
      n_checks++;
      if (k < 16) begin
        if ({timeout_o, m_err_o} !== 5'b0) begin
          n_fail++; $display("FAIL to_early%0d: got %b expected 00000", k, {timeout_o, m_err_o});
        end
      end else begin
        if ({timeout_o, m_err_o} !== 5'b10001) begin
          n_fail++; $display("FAIL to_fire: got %b expected 10001", {timeout_o, m_err_o});
        end
      end
    end
    @(negedge clk);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    #1;
    n_checks++;
    if ({timeout_o, m_err_o} !== 5'b0) begin
      n_fail++; $display("FAIL to_single_pulse: got %b expected 00000", {timeout_o, m_err_o});
    end
    @(negedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 16) s_err_i = 1'b1;
      #1;
      if (k == 1) begin
        n_checks++;
        if (grant_o !== 4'b0010) begin
          n_fail++; $display("FAIL to_grant1: got %b expected 0010", grant_o);
        end
      end
      if (k == 16) begin
        n_checks++;
        if ({timeout_o, m_err_o} !== 5'b00010) begin
          n_fail++; $display("FAIL to_real_err_wins: got %b expected 00010", {timeout_o, m_err_o});
        end
      end
    end
    @(negedge clk);
    s_err_i = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    m_cyc[MASTER_ICACHE] = 1'b1; m_stb[MASTER_ICACHE] = 1'b1;
    m_adr[MASTER_ICACHE] = 32'h8000_0010;
    @(negedge clk); #1;
    n_checks++;
    if ({grant_o, s_cyc_o} !== 5'b10001) begin
      n_fail++; $display("FAIL arst_pre: got %b expected 10001", {grant_o, s_cyc_o});
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({grant_o, s_cyc_o, s_stb_o} !== 6'b0) begin
      n_fail++; $display("FAIL arst_drop: got %b expected 000000", {grant_o, s_cyc_o, s_stb_o});
    end
    @(negedge clk);
    m_cyc[MASTER_DMMU] = 1'b1; m_stb[MASTER_DMMU] = 1'b1;
    rst = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (grant_o !== 4'b0001) begin
      n_fail++; $display("FAIL arst_ptr_cleared: got %b expected 0001", grant_o);
    end
    @(negedge clk);
    m_cyc = '0; m_stb = '0;
    @(negedge clk);
  endtask

  task automatic test_flush_abandon();
    @(negedge clk);
    m_cyc[MASTER_IMMU] = 1'b1; m_stb[MASTER_IMMU] = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (grant_o !== 4'b0010) begin
      n_fail++; $display("FAIL flush_grant: got %b expected 0010", grant_o);
    end
    @(negedge clk);
    m_cyc[MASTER_IMMU] = 1'b0; m_stb[MASTER_IMMU] = 1'b0;
    #1;
    n_checks++;
    if ({m_ack_o, s_cyc_o} !== 5'b0) begin
      n_fail++; $display("FAIL flush_drop: got %b expected 00000", {m_ack_o, s_cyc_o});
    end
    @(negedge clk);
    s_ack_i = 1'b1;
    #1;
    n_checks++;
    if ({m_ack_o, grant_o, s_cyc_o} !== 9'b0) begin
      n_fail++; $display("FAIL flush_late_ack: got %b expected 000000000", {m_ack_o, grant_o, s_cyc_o});
    end
    @(negedge clk);
    s_ack_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_refill_no_preempt();
    test_timeout();
    test_async_reset();
    test_flush_abandon();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
